// File: rtl/fetch_jump_sequencer.sv
// rtl/fetch_jump_sequencer.sv - hardwired fetch / jump-class control sequencer for Datapath2
//
// Purpose: drives the T-step control strobes for instruction fetch (T0-T2) and
// the jump class (jal, jr, conditional branch). It waits on memory-ready during
// the read, faults on a read timeout, stops on halt, and hands every other
// opcode to the ALU-op sequencer.
//
// Ports:
//   clk, clr                  clock; synchronous active-high clear
//   run                       start/continue fetching (sampled in IDLE and END)
//   ir_opcode                 IR[31:27], decoded in DEC
//   con_ff                    CON flip-flop, consulted in B6 only
//   mem_ready                 memory read data valid on MDR input
//   exec_done                 ALU-op sequencer finished the current instruction
//   PCout..Yin                datapath strobes
//   Gra,Rout,CONin,Cout,link_in  register-select / CON / C / R15-write strobes
//   alu_op                    ALU_Control (nonzero only in T0 and B5)
//   exec_req, halted, fault   handoff request, halt state, sticky read timeout
//   tstep                     current T-step index for debug
module fetch_jump_sequencer #(
  parameter int                OPC_W       = 5,
  parameter logic [OPC_W-1:0]  JAL_OP      = 5'd21,
  parameter logic [OPC_W-1:0]  JR_OP       = 5'd20,
  parameter logic [OPC_W-1:0]  BR_OP       = 5'd18,
  parameter logic [OPC_W-1:0]  HALT_OP     = 5'd27,
  parameter logic [OPC_W-1:0]  ALU_INC     = 5'd12,
  parameter logic [OPC_W-1:0]  ALU_ADD     = 5'd2,
  parameter int                MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             con_ff,
  input  logic             mem_ready,
  input  logic             exec_done,
  output logic             PCout,
  output logic             PCin,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Read,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Yin,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic             Cout,
  output logic             link_in,
  output logic [OPC_W-1:0] alu_op,
  output logic             exec_req,
  output logic             halted,
  output logic             fault,
  output logic [3:0]       tstep
);

  localparam logic [4:0] S_IDLE  = 5'd0;
  localparam logic [4:0] S_T0    = 5'd1;
  localparam logic [4:0] S_T1    = 5'd2;
  localparam logic [4:0] S_RD    = 5'd3;
  localparam logic [4:0] S_LD    = 5'd4;
  localparam logic [4:0] S_T2    = 5'd5;
  localparam logic [4:0] S_DEC   = 5'd6;
  localparam logic [4:0] S_J3    = 5'd7;
  localparam logic [4:0] S_J4    = 5'd8;
  localparam logic [4:0] S_R3    = 5'd9;
  localparam logic [4:0] S_B3    = 5'd10;
  localparam logic [4:0] S_B4    = 5'd11;
  localparam logic [4:0] S_B5    = 5'd12;
  localparam logic [4:0] S_B6    = 5'd13;
  localparam logic [4:0] S_X     = 5'd14;
  localparam logic [4:0] S_END   = 5'd15;
  localparam logic [4:0] S_HALT  = 5'd16;
  localparam logic [4:0] S_FAULT = 5'd17;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [4:0]       state;
  logic [4:0]       next_state;
  logic [CNT_W-1:0] rd_count;

  // rd_count is zero on the first RD cycle (it is held clear outside RD), so
  // the FAULT transition happens on the MEM_TIMEOUT-th RD cycle without ready.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      rd_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_RD && !mem_ready)
        rd_count <= rd_count + 1'b1;
      else
        rd_count <= '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (run) next_state = S_T0;
      S_T0:    next_state = S_T1;
      S_T1:    next_state = S_RD;
      S_RD: begin
        if (mem_ready)                  next_state = S_LD;
        else if (rd_count == CNT_LAST)  next_state = S_FAULT;
      end
      S_LD:    next_state = S_T2;
      S_T2:    next_state = S_DEC;
      S_DEC: begin
        if      (ir_opcode == JAL_OP)  next_state = S_J3;
        else if (ir_opcode == JR_OP)   next_state = S_R3;
        else if (ir_opcode == BR_OP)   next_state = S_B3;
        else if (ir_opcode == HALT_OP) next_state = S_HALT;
        else                           next_state = S_X;
      end
      S_J3:    next_state = S_J4;
      S_J4:    next_state = S_END;
      S_R3:    next_state = S_END;
      S_B3:    next_state = S_B4;
      S_B4:    next_state = S_B5;
      S_B5:    next_state = S_B6;
      S_B6:    next_state = S_END;
      S_X:     if (exec_done) next_state = S_END;
      S_END:   next_state = run ? S_T0 : S_IDLE;
      S_HALT:  next_state = S_HALT;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Read     = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Yin      = 1'b0;
    Gra      = 1'b0;
    Rout     = 1'b0;
    CONin    = 1'b0;
    Cout     = 1'b0;
    link_in  = 1'b0;
    alu_op   = '0;
    exec_req = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    tstep    = 4'd0;
    case (state)
      S_T0:    begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; alu_op = ALU_INC; end
      S_T1:    begin Zlowout = 1'b1; PCin = 1'b1; tstep = 4'd1; end
      S_RD:    begin Read = 1'b1; tstep = 4'd1; end
      S_LD:    begin Read = 1'b1; MDRin = 1'b1; tstep = 4'd1; end
      S_T2:    begin MDRout = 1'b1; IRin = 1'b1; tstep = 4'd2; end
      S_DEC:   tstep = 4'd3;
      S_J3:    begin PCout = 1'b1; link_in = 1'b1; tstep = 4'd3; end
      S_J4:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; tstep = 4'd4; end
      S_R3:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; tstep = 4'd3; end
      S_B3:    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; tstep = 4'd3; end
      S_B4:    begin PCout = 1'b1; Yin = 1'b1; tstep = 4'd4; end
      S_B5:    begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; tstep = 4'd5; end
      // Branch taken: the PC+C sum waiting in Z is written to PC.
      S_B6:    begin Zlowout = con_ff; PCin = con_ff; tstep = 4'd6; end
      S_X:     begin exec_req = 1'b1; tstep = 4'd3; end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_jump_sequencer.sv
// tb/tb_fetch_jump_sequencer.sv - self-checking bench for fetch_jump_sequencer
module tb_fetch_jump_sequencer;

  typedef struct packed {
    logic       PCout, PCin, MARin, MDRin, MDRout, IRin, Read, Zin, Zlowout, Yin;
    logic       Gra, Rout, CONin, Cout, link_in;
    logic [4:0] alu_op;
    logic       exec_req, halted, fault;
    logic [3:0] tstep;
  } outs_t;

  logic       clk = 1'b0;
  logic       clr, run, con_ff, mem_ready, exec_done;
  logic [4:0] ir_opcode;
  logic       PCout, PCin, MARin, MDRin, MDRout, IRin, Read, Zin, Zlowout, Yin;
  logic       Gra, Rout, CONin, Cout, link_in;
  logic [4:0] alu_op;
  logic       exec_req, halted, fault;
  logic [3:0] tstep;

  outs_t act;
  outs_t exp_vec;
  string exp_name;
  bit    exp_valid = 1'b0;
  int    checks = 0;
  int    failures = 0;
  int    read_only_cnt = 0;
  int    mdrin_cnt = 0;
  int    exec_cnt = 0;
  int    link_cnt = 0;

  always #5 clk = ~clk;

  fetch_jump_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .ir_opcode(ir_opcode), .con_ff(con_ff),
    .mem_ready(mem_ready), .exec_done(exec_done),
    .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Read(Read), .Zin(Zin), .Zlowout(Zlowout), .Yin(Yin),
    .Gra(Gra), .Rout(Rout), .CONin(CONin), .Cout(Cout), .link_in(link_in),
    .alu_op(alu_op), .exec_req(exec_req), .halted(halted), .fault(fault), .tstep(tstep)
  );

  always_comb act = {PCout, PCin, MARin, MDRin, MDRout, IRin, Read, Zin, Zlowout, Yin,
                     Gra, Rout, CONin, Cout, link_in, alu_op, exec_req, halted, fault, tstep};

  // Expected outputs of one named step, straight from the step table.
  function automatic outs_t step_vec(string name, bit con);
    outs_t o = '0;
    case (name)
      "T0":    begin o.PCout = 1; o.MARin = 1; o.Zin = 1; o.alu_op = 5'd12; end
      "T1":    begin o.Zlowout = 1; o.PCin = 1; o.tstep = 1; end
      "RD":    begin o.Read = 1; o.tstep = 1; end
      "LD":    begin o.Read = 1; o.MDRin = 1; o.tstep = 1; end
      "T2":    begin o.MDRout = 1; o.IRin = 1; o.tstep = 2; end
      "DEC":   o.tstep = 3;
      "J3":    begin o.PCout = 1; o.link_in = 1; o.tstep = 3; end
      "J4":    begin o.Gra = 1; o.Rout = 1; o.PCin = 1; o.tstep = 4; end
      "R3":    begin o.Gra = 1; o.Rout = 1; o.PCin = 1; o.tstep = 3; end
      "B3":    begin o.Gra = 1; o.Rout = 1; o.CONin = 1; o.tstep = 3; end
      "B4":    begin o.PCout = 1; o.Yin = 1; o.tstep = 4; end
      "B5":    begin o.Cout = 1; o.Zin = 1; o.alu_op = 5'd2; o.tstep = 5; end
      "B6":    begin o.Zlowout = con; o.PCin = con; o.tstep = 6; end
      "X":     begin o.exec_req = 1; o.tstep = 3; end
      "HALT":  o.halted = 1;
      "FAULT": o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_vec) begin
        failures++;
        $display("FAIL step %s actual=%h required=%h", exp_name, act, exp_vec);
      end
      if (act.Read && !act.MDRin) read_only_cnt++;
      if (act.MDRin) mdrin_cnt++;
      if (act.exec_req) exec_cnt++;
      if (act.link_in) link_cnt++;
    end
  end

  task automatic check_eq(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic reset_counts();
    read_only_cnt = 0;
    mdrin_cnt = 0;
    exec_cnt = 0;
    link_cnt = 0;
  endtask

  task automatic expect_step(string name, bit con);
    exp_name = name;
    exp_vec = step_vec(name, con);
    exp_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Build the whole expected step list for one instruction, then walk it one
  // cycle per entry. mem_delay < 0 means memory never answers.
  task automatic run_seq(input logic [4:0] opc, input int mem_delay, input bit con,
                         input int exec_delay, input bit from_idle, input bit run_after,
                         input bit clr_at_b5);
    string q[$];
    bit    clr_last = 1'b0;
    int    rd_seen = 0;
    int    x_seen = 0;
    if (from_idle) q.push_back("IDLE");
    q.push_back("T0");
    q.push_back("T1");
    if (mem_delay < 0) begin
      repeat (16) q.push_back("RD");
      repeat (3) q.push_back("FAULT");
      clr_last = 1'b1;
    end else begin
      repeat (mem_delay + 1) q.push_back("RD");
      q.push_back("LD");
      q.push_back("T2");
      q.push_back("DEC");
      case (opc)
        5'd21: begin q.push_back("J3"); q.push_back("J4"); end
        5'd20: q.push_back("R3");
        5'd18: begin
          q.push_back("B3"); q.push_back("B4"); q.push_back("B5");
          if (clr_at_b5) clr_last = 1'b1;
          else q.push_back("B6");
        end
        5'd27: begin repeat (3) q.push_back("HALT"); clr_last = 1'b1; end
        default: repeat (exec_delay + 1) q.push_back("X");
      endcase
      if (!clr_last) q.push_back("END");
    end
    ir_opcode = opc;
    con_ff = con;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == "END") run = run_after;
      else if (q[i] == "HALT" || q[i] == "FAULT") run = (i % 2) == 1;
      else run = 1'b1;
      mem_ready = (q[i] == "RD" && rd_seen == mem_delay) || q[i] == "FAULT";
      exec_done = (q[i] == "X" && x_seen == exec_delay);
      clr = clr_last && (i == q.size() - 1);
      if (q[i] == "RD") rd_seen++;
      if (q[i] == "X") x_seen++;
      expect_step(q[i], con);
    end
    clr = 1'b0;
    mem_ready = 1'b0;
    exec_done = 1'b0;
    if (clr_last) begin
      run = 1'b0;
      expect_step("IDLE", con);
    end
  endtask

  initial begin
    clr = 1'b1; run = 1'b1; ir_opcode = '0; con_ff = 1'b0;
    mem_ready = 1'b1; exec_done = 1'b1;
    @(posedge clk);
    #1;
    // clr held with every other input active: outputs stay idle
    repeat (2) expect_step("RESET", 1'b0);
    clr = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    check_eq("reset_outputs_zero", int'(act == '0), 1);

    // jal then jr back-to-back (END with run=1 goes straight to T0)
    reset_counts();
    run_seq(5'd21, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    check_eq("jal_link_in_cycles", link_cnt, 1);
    run_seq(5'd20, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // conditional branch, not taken then taken
    run_seq(5'd18, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    run_seq(5'd18, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);

    // memory ready three cycles late
    reset_counts();
    run_seq(5'd20, 3, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("delayed_read_rd_cycles", read_only_cnt, 4);
    check_eq("delayed_read_mdrin_cycles", mdrin_cnt, 1);

    // handoff to the ALU-op sequencer, exec_done on the fifth cycle
    reset_counts();
    run_seq(5'd5, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    check_eq("exec_req_cycles", exec_cnt, 5);

    // clear in the middle of B5
    run_seq(5'd18, 1, 1'b1, 0, 1'b1, 1'b0, 1'b1);
    check_eq("clr_mid_b5_fault", int'(fault), 0);

    // memory never ready: fault after 16 RD cycles
    reset_counts();
    run_seq(5'd20, -1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("timeout_rd_cycles", read_only_cnt, 16);

    // halt, run toggling ignored until clr
    run_seq(5'd27, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("after_halt_clr_halted", int'(halted), 0);

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
